// File: rtl/pc_next_reg.sv
// pc_next_reg: registered PC with prioritised next-PC select and a stall pending slot; exception path under `ifdef PC_EXC_EN
module pc_next_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
`ifdef PC_EXC_EN
  , parameter logic [63:0] EXC_VEC = 64'h0000_0180
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_br_take,
  input  logic [WIDTH-1:0] i_br_tgt,
  input  logic             i_j_take,
  input  logic [WIDTH-1:0] i_j_tgt,
  input  logic             i_jr_take,
  input  logic [WIDTH-1:0] i_jr_tgt,
`ifdef PC_EXC_EN
  input  logic             i_exc,
`endif
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic             o_redirect,
  output logic             o_pend,
  output logic             o_misalign
);
  logic [WIDTH-1:0] sel, tgt, pend_tgt;
  logic req, mis, pend_mis;
`ifdef PC_EXC_EN
  localparam logic [WIDTH-1:0] EXC_RAW = EXC_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EXC_TGT = {EXC_RAW[WIDTH-1:2], 2'b00};
  localparam logic EXC_MIS = |EXC_RAW[1:0];
`endif
  // jump-register beats jump beats branch; target is word-aligned before use
  always_comb begin
    sel = i_jr_take ? i_jr_tgt : i_j_take ? i_j_tgt : i_br_tgt;
    req = i_jr_take | i_j_take | i_br_take;
    tgt = {sel[WIDTH-1:2], 2'b00};
    mis = |sel[1:0];
  end
  assign o_pc_plus4 = o_pc + WIDTH'(4);
  // PC update: an older captured redirect wins over newer requests, except an exception
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      o_pc <= RESET_VEC;
      o_redirect <= 1'b0;
      o_pend <= 1'b0;
      o_misalign <= 1'b0;
      pend_tgt <= '0;
      pend_mis <= 1'b0;
    end
`ifdef PC_EXC_EN
    else if (i_exc) begin
      o_misalign <= !i_stall && EXC_MIS;
      if (i_stall) begin
        o_pend <= 1'b1;
        pend_tgt <= EXC_TGT;
        pend_mis <= EXC_MIS;
      end else begin
        o_pc <= EXC_TGT;
        o_pend <= 1'b0;
        o_redirect <= 1'b1;
      end
    end
`endif
    else if (i_stall) begin
      o_misalign <= 1'b0;
      if (!o_pend && req) begin
        o_pend <= 1'b1;
        pend_tgt <= tgt;
        pend_mis <= mis;
      end
    end else if (o_pend) begin
      o_pc <= pend_tgt;
      o_pend <= 1'b0;
      o_redirect <= 1'b1;
      o_misalign <= pend_mis;
    end else begin
      o_pc <= req ? tgt : o_pc_plus4;
      o_redirect <= req;
      o_misalign <= req && mis;
    end
endmodule

// File: doc/pc_next_reg.md
# pc_next_reg

Registered program-counter stage that replaces the fixed two-input next-PC select with a parametrised, prioritised multi-source selector. It holds the current PC, computes the sequential address, chooses among branch, jump, jump-register and (optionally) exception redirects, and keeps a redirect that arrives while fetch is stalled. It sits at the front of the datapath, feeding instruction-memory address and the PC+4 link value.

## Interface
Parameters:
- `WIDTH`, 32: address width in bits; legal range 8..64.
- `RESET_VEC`, 0: PC value loaded on reset; low 2 bits must be 0.
- `EXC_VEC`, 32'h0000_0180: exception entry address, truncated or zero-extended to `WIDTH`; used only with `PC_EXC_EN`.

Ports:
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_stall` in 1: hold PC this cycle.
- `i_br_take` in 1: taken-branch request.
- `i_br_tgt` in WIDTH: branch target address.
- `i_j_take` in 1: jump request.
- `i_j_tgt` in WIDTH: jump target address.
- `i_jr_take` in 1: jump-register request.
- `i_jr_tgt` in WIDTH: register target address.
- `i_exc` in 1: exception request; present only with `PC_EXC_EN`.
- `o_pc` out WIDTH: current PC, registered.
- `o_pc_plus4` out WIDTH: `o_pc + 4`, combinational, modulo 2^WIDTH.
- `o_redirect` out 1: registered; 1 when the current `o_pc` was loaded from a redirect or pending target.
- `o_pend` out 1: registered; a captured redirect is waiting.
- `o_misalign` out 1: registered; the redirect target loaded this cycle had nonzero bits [1:0].

## Operation
- Priority, highest first: exception, jump-register, jump, branch, sequential (`o_pc_plus4`).
- Selected redirect target is forced to a word boundary: bits [1:0] cleared before loading. `o_misalign` reports the original bits.
- Pending slot: one target register plus a valid bit (`o_pend`).
- Not stalled, no pending: PC loads the highest-priority active request, or `o_pc_plus4` if none.
- Stalled, no pending: PC holds. Any active request is captured into the pending slot by priority, and `o_pend` sets.
- Stalled, pending valid: PC holds. New requests are ignored, because the older redirect wins. The exception is `i_exc`, which always overwrites the pending slot with `EXC_VEC`.
- Not stalled, pending valid: PC loads the pending target and `o_pend` clears. Same-cycle requests are ignored, except `i_exc`, which takes precedence and loads `EXC_VEC`.
- `o_redirect` is 1 for the cycle after any non-sequential load, whether direct or from pending; otherwise 0. It holds its value while stalled.
- Sequential increment wraps: `o_pc` = 2^WIDTH−4 is followed by 0.

## Timing
- Reset at an edge with `i_rst_n`=0: `o_pc`=`RESET_VEC`; `o_redirect`, `o_pend`, `o_misalign` = 0. The pending slot is cleared.
- Reset has priority over stall and all requests, including mid-stall with a pending redirect.
- Redirect latency: a request in cycle n with `i_stall`=0 gives the target on `o_pc` in cycle n+1.
- Stalled redirect: a request in cycle n with stall, and stall first low in cycle m, gives the target on `o_pc` in cycle m+1.
- `o_pc_plus4` has zero latency from `o_pc`.
- `o_misalign` is a one-cycle pulse aligned with the `o_pc` it describes.

## Configuration
- `PC_EXC_EN` defined:
  - `i_exc` port exists.
  - Exception is the top priority and loads `EXC_VEC`.
  - Exception overrides the pending slot.
- `PC_EXC_EN` undefined:
  - `i_exc` port is absent.
  - The priority chain starts at jump-register.
  - `EXC_VEC` is unused.
  - No logic is generated for the exception path.

## Test plan
- Reset: hold `i_rst_n`=0 for 2 cycles with `RESET_VEC`=0x0040_0000 → `o_pc`=0x0040_0000, flags 0. Release, then 3 free cycles → `o_pc`=0x0040_000C and `o_pc_plus4`=0x0040_0010.
- Priority: in one cycle assert `i_br_take` (0x100), `i_j_take` (0x200) and `i_jr_take` (0x300) → next `o_pc`=0x300 with `o_redirect`=1. Next cycle `o_pc`=0x304 with `o_redirect`=0.
- Stall capture: `i_stall`=1 for 3 cycles, `i_br_tgt`=0x80 with take in the first stall cycle, then `i_j_take` in the second → `o_pend`=1 and PC held throughout. When stall drops, `o_pc`=0x80 (not the jump target) and `o_pend`=0.
- Misalign and wrap: a jr target of 0x1003 → `o_pc`=0x1000 and `o_misalign`=1 for one cycle. Set `o_pc`=0xFFFF_FFFC with no request → next `o_pc`=0.
- Exception (`PC_EXC_EN`): while stalled with a branch pending, assert `i_exc` → after stall release, `o_pc`=0x180.
- Reset mid-stall with a pending redirect → `o_pend`=0 and `o_pc`=`RESET_VEC`.
